// File: rtl/gate_ctrl_pkg.sv
// Shared constants, parser state encoding and frame check helper for the
// UART-driven gate PWM bank.
package gate_ctrl_pkg;

  localparam int DUTY_W = 8;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHAN  = 2'd1,
    ST_DUTY  = 2'd2,
    ST_CHECK = 2'd3
  } parser_state_e;

  function automatic logic [7:0] frame_check(input logic [7:0] chan,
                                             input logic [DUTY_W-1:0] duty);
    return chan ^ duty;
  endfunction

endpackage

// File: rtl/pwm_cmd_parser.sv
// Four-byte command frame parser: SYNC, channel, duty, check. Emits a
// registered commit strobe or error pulse one cycle after the check byte.
module pwm_cmd_parser
  import gate_ctrl_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              commit,
  output logic [3:0]        commit_idx,
  output logic [DUTY_W-1:0] commit_duty,
  output logic              frame_err,
  output parser_state_e     state_o
);

  // Handshake: a byte moves when in_valid and in_ready are both high on a
  // rising edge; in_ready is low only while reset is held.
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0] CH_LIMIT = 8'(CHANNELS);

  parser_state_e     state_q, state_d;
  logic [7:0]        chan_q, chan_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              commit_q, commit_d;
  logic [3:0]        cidx_q, cidx_d;
  logic [DUTY_W-1:0] cduty_q, cduty_d;
  logic              err_q, err_d;
  logic              ready_q, ready_d;
  logic              hs;

  assign hs = in_valid && ready_q;

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    duty_d   = duty_q;
    timer_d  = timer_q;
    commit_d = 1'b0;
    cidx_d   = cidx_q;
    cduty_d  = cduty_q;
    err_d    = 1'b0;
    ready_d  = 1'b1;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (hs && in_data == SYNC_BYTE) state_d = ST_CHAN;
      end
      ST_CHAN: begin
        if (hs) begin
          chan_d  = in_data;
          state_d = ST_DUTY;
        end
      end
      ST_DUTY: begin
        if (hs) begin
          duty_d  = in_data;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (hs) begin
          state_d = ST_IDLE;
          if (in_data == frame_check(chan_q, duty_q) && chan_q < CH_LIMIT) begin
            commit_d = 1'b1;
            cidx_d   = chan_q[3:0];
            cduty_d  = duty_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Mid-frame inactivity watchdog; a byte arriving on the expiry cycle wins.
    if (state_q != ST_IDLE) begin
      if (hs) begin
        timer_d = '0;
      end else if (timer_q == TIMER_LAST) begin
        timer_d = '0;
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      chan_q   <= '0;
      duty_q   <= '0;
      timer_q  <= '0;
      commit_q <= 1'b0;
      cidx_q   <= '0;
      cduty_q  <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      duty_q   <= duty_d;
      timer_q  <= timer_d;
      commit_q <= commit_d;
      cidx_q   <= cidx_d;
      cduty_q  <= cduty_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

  assign in_ready    = ready_q;
  assign commit      = commit_q;
  assign commit_idx  = cidx_q;
  assign commit_duty = cduty_q;
  assign frame_err   = err_q;
  assign state_o     = state_q;

endmodule

// File: rtl/gate_pwm_bank.sv
// PWM bank: shared prescaled 8-bit counter, per-channel shadow duty that is
// only transferred to the active duty at counter wrap.
module gate_pwm_bank
  import gate_ctrl_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 1,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                frame_ok,
  output logic                frame_err,
  output logic [7:0]          err_count,
  output logic [1:0]          dbg_state
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  logic              commit;
  logic [3:0]        commit_idx;
  logic [DUTY_W-1:0] commit_duty;
  logic              parse_err;
  parser_state_e     parse_state;

  logic [15:0]                        presc_q, presc_d;
  logic [7:0]                         cnt_q, cnt_d;
  logic [CHANNELS-1:0][DUTY_W-1:0]    shadow_q, shadow_d;
  logic [CHANNELS-1:0][DUTY_W-1:0]    active_q, active_d;
  logic [7:0]                         err_cnt_q, err_cnt_d;
  logic                               step;
  logic                               wrap;

  pwm_cmd_parser #(
    .CHANNELS (CHANNELS),
    .TIMEOUT  (TIMEOUT)
  ) u_parser (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .commit      (commit),
    .commit_idx  (commit_idx),
    .commit_duty (commit_duty),
    .frame_err   (parse_err),
    .state_o     (parse_state)
  );

  assign step = (presc_q == PS_LAST);
  assign wrap = step && (cnt_q == 8'hFF);

  always_comb begin
    presc_d   = step ? 16'd0 : presc_q + 16'd1;
    cnt_d     = cnt_q + {7'd0, step};
    // Active copy reads the pre-commit shadow, so a commit on the wrap
    // cycle waits a full period.
    active_d  = wrap ? shadow_q : active_q;
    shadow_d  = shadow_q;
    if (commit) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (commit_idx == 4'(i)) shadow_d[i] = commit_duty;
      end
    end
    err_cnt_d = err_cnt_q;
    if (parse_err && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q   <= '0;
      cnt_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    pwm_out = '0;
    for (int i = 0; i < CHANNELS; i++) pwm_out[i] = (cnt_q < active_q[i]);
  end

  assign frame_ok  = commit;
  assign frame_err = parse_err;
  assign err_count = err_cnt_q;
  assign dbg_state = parse_state;

endmodule
